kernel_launcher: RTL and testbench

KERNEL_LAUNCHER -- requirements
Module: kernel_launcher

---
 rtl/kernel_launcher.sv | 101 ++++++++++
 tb/tb_kernel_launcher.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/kernel_launcher.sv
// kernel_launcher: sequences accelerator launches (optional reconfig, start, run with watchdog, response).
module kernel_launcher #(
  parameter int ID_W  = 4,
  parameter int CNT_W = 32,
  parameter int TO_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_new_conf_i,
  input  logic [ID_W-1:0]  req_id_i,
  input  logic [TO_W-1:0]  timeout_i,
  output logic             conf_change_o,
  output logic             start_o,
  input  logic             cu_exec_i,
  input  logic             cu_done_i,
  output logic             cu_clr_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [ID_W-1:0]  rsp_id_o,
  output logic [CNT_W-1:0] rsp_cycles_o,
  output logic             rsp_err_o,
  output logic             busy_o
);
  typedef enum logic [2:0] {L_IDLE, L_CONF, L_START, L_RUN, L_RESP} state_e;
  state_e           state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [TO_W-1:0]  to_q, to_d, wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             fire;
  // Completion wins over a coincident timeout, so fire is masked by cu_done_i.
  assign fire = state_q == L_RUN && to_q != '0 && wd_q == to_q - TO_W'(1) && !cu_done_i;
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    to_d    = to_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      L_IDLE: if (req_valid_i) begin
        id_d    = req_id_i;
        to_d    = timeout_i;
        cnt_d   = '0;
        wd_d    = '0;
        err_d   = 1'b0;
        state_d = req_new_conf_i ? L_CONF : L_START;
      end
      L_CONF:  state_d = L_START;
      L_START: state_d = L_RUN;
      L_RUN: begin
        cnt_d = (cu_exec_i && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        wd_d  = wd_q + TO_W'(1);
        if (cu_done_i) state_d = L_RESP;
        else if (fire) begin
          state_d = L_RESP;
          err_d   = 1'b1;
        end
      end
      L_RESP:  state_d = rsp_ready_i ? L_IDLE : L_RESP;
      default: state_d = L_IDLE;
    endcase
    if (clr_i) begin
      state_d = L_IDLE;
      id_d    = '0;
      to_d    = '0;
      wd_d    = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= L_IDLE;
      id_q    <= '0;
      to_q    <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      to_q    <= to_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign req_ready_o   = state_q == L_IDLE;
  assign conf_change_o = state_q == L_CONF;
  assign start_o       = state_q == L_START;
  assign rsp_valid_o   = state_q == L_RESP;
  assign busy_o        = state_q != L_IDLE;
  assign cu_clr_o      = clr_i | fire;
  assign rsp_id_o      = id_q;
  assign rsp_cycles_o  = cnt_q;
  assign rsp_err_o     = err_q;
endmodule

// File: tb/tb_kernel_launcher.sv
// tb_kernel_launcher: directed launches against a timeline model of the launcher protocol.
module tb_kernel_launcher;
  localparam int CW = 4;
  logic clk = 1'b0, rst_ni = 1'b0, clr_i = 1'b0;
  logic req_valid_i = 1'b0, req_new_conf_i = 1'b0, cu_exec_i = 1'b0, cu_done_i = 1'b0, rsp_ready_i = 1'b0;
  logic [3:0] req_id_i = '0;
  logic [15:0] timeout_i = '0;
  logic req_ready_o, conf_change_o, start_o, cu_clr_o, rsp_valid_o, rsp_err_o, busy_o;
  logic [3:0] rsp_id_o;
  logic [CW-1:0] rsp_cycles_o;

  kernel_launcher #(.ID_W(4), .CNT_W(CW), .TO_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_new_conf_i(req_new_conf_i),
    .req_id_i(req_id_i), .timeout_i(timeout_i), .conf_change_o(conf_change_o), .start_o(start_o),
    .cu_exec_i(cu_exec_i), .cu_done_i(cu_done_i), .cu_clr_o(cu_clr_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_cycles_o(rsp_cycles_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic chk_en = 1'b0;
  logic e_ready, e_conf, e_start, e_clr, e_valid, e_err, e_busy;
  logic [3:0] e_id;
  logic [CW-1:0] e_cycles;
  int cap_conf, cap_start, cap_clr;
  logic [31:0] cap_id, cap_cycles, cap_err;

  task automatic cmp(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    cmp("req_ready", 32'(req_ready_o), 32'(e_ready));
    cmp("busy", 32'(busy_o), 32'(e_busy));
    cmp("conf_change", 32'(conf_change_o), 32'(e_conf));
    cmp("start", 32'(start_o), 32'(e_start));
    cmp("cu_clr", 32'(cu_clr_o), 32'(e_clr));
    cmp("rsp_valid", 32'(rsp_valid_o), 32'(e_valid));
    if (e_valid) begin
      cmp("rsp_id", 32'(rsp_id_o), 32'(e_id));
      cmp("rsp_cycles", 32'(rsp_cycles_o), 32'(e_cycles));
      cmp("rsp_err", 32'(rsp_err_o), 32'(e_err));
    end
  end

  // One launch laid out as a timeline from the accept cycle (c=0): e = exec cycles,
  // k = run cycle of cu_done_i (0 = never), d = response wait, hv = hold a next request.
  task automatic launch(input int id, input int nc, input int to, input int e, input int k,
                        input int d, input int hv = 0, input int hid = 0, input int hnc = 0);
    int s, l, n, cy, rc;
    bit err, run;
    s   = 1 + nc;
    err = to != 0 && (k == 0 || k > to);
    l   = err ? to : k;
    cy  = e < l ? e : l;
    if (cy > (1 << CW) - 1) cy = (1 << CW) - 1;
    n   = s + l + 2 + d;
    cap_conf = -1; cap_start = -1; cap_clr = -1;
    for (int c = 0; c < n; c++) begin
      rc  = c - s;
      run = c > s && c <= s + l;
      req_valid_i    = c == 0 || hv != 0;
      req_id_i       = 4'(c == 0 ? id : hid);
      req_new_conf_i = (c == 0 ? nc : hnc) != 0;
      timeout_i      = c == 0 ? 16'(to) : 16'($urandom);
      cu_exec_i      = (run && rc <= e) || c == s;
      cu_done_i      = (run && rc == k) || c == s || c > s + l;
      rsp_ready_i    = c == n - 1;
      e_ready = c == 0; e_busy = c != 0; e_conf = nc != 0 && c == 1; e_start = c == s;
      e_clr = err && run && rc == l; e_valid = c > s + l;
      e_id = 4'(id); e_cycles = CW'(cy); e_err = err;
      @(negedge clk);
      if (conf_change_o) cap_conf = c;
      if (start_o) cap_start = c;
      if (cu_clr_o) cap_clr = c;
      if (c == n - 1) begin
        cap_id = 32'(rsp_id_o); cap_cycles = 32'(rsp_cycles_o); cap_err = 32'(rsp_err_o);
      end
      @(posedge clk); #1;
    end
  endtask

  // Clear at run cycle j, then a request blocked by a simultaneous clear in idle.
  task automatic clr_launch(input int id, input int nc, input int j);
    int s, n;
    s = 1 + nc;
    n = s + j + 3;
    for (int c = 0; c < n; c++) begin
      req_valid_i = c == 0 || c == s + j + 1;
      req_id_i = 4'(id); req_new_conf_i = nc != 0; timeout_i = '0;
      cu_exec_i = c > s; cu_done_i = 1'b0; rsp_ready_i = 1'b1;
      clr_i = c == s + j || c == s + j + 1;
      e_ready = c == 0 || c > s + j; e_busy = c > 0 && c <= s + j;
      e_conf = nc != 0 && c == 1; e_start = c == s; e_clr = clr_i; e_valid = 1'b0;
      @(negedge clk);
      if (c > s + j) begin
        cmp("clr_rsp_id", 32'(rsp_id_o), 0);
        cmp("clr_rsp_cycles", 32'(rsp_cycles_o), 0);
        cmp("clr_rsp_err", 32'(rsp_err_o), 0);
      end
      @(posedge clk); #1;
    end
    clr_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_ready", 32'(req_ready_o), 1);
    cmp("rst_busy", 32'(busy_o), 0);
    cmp("rst_valid", 32'(rsp_valid_o), 0);
    cmp("rst_start", 32'(start_o), 0);
    cmp("rst_id", 32'(rsp_id_o), 0);
    cmp("rst_cycles", 32'(rsp_cycles_o), 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    chk_en = 1'b1;
    launch(3, 1, 0, 10, 11, 2);
    cmp("t1_conf_at", 32'(cap_conf), 1);
    cmp("t1_start_at", 32'(cap_start), 2);
    cmp("t1_id", cap_id, 3);
    cmp("t1_cycles", cap_cycles, 10);
    cmp("t1_err", cap_err, 0);
    launch(5, 0, 0, 3, 4, 0);
    cmp("t2_conf_at", 32'(cap_conf), 32'hFFFF_FFFF);
    cmp("t2_start_at", 32'(cap_start), 1);
    cmp("t2_id", cap_id, 5);
    launch(7, 0, 8, 5, 0, 1);
    cmp("t3_clr_at", 32'(cap_clr), 9);
    cmp("t3_err", cap_err, 1);
    cmp("t3_cycles", cap_cycles, 5);
    launch(9, 1, 8, 8, 8, 0);
    cmp("t4_clr_at", 32'(cap_clr), 32'hFFFF_FFFF);
    cmp("t4_err", cap_err, 0);
    cmp("t4_cycles", cap_cycles, 8);
    launch(2, 0, 0, 4, 5, 20, 1, 12, 1);
    cmp("t5_id", cap_id, 2);
    launch(12, 1, 0, 20, 22, 0);
    cmp("t6_cycles_sat", cap_cycles, 15);
    launch(4, 0, 1, 1, 0, 0);
    cmp("t7_err", cap_err, 1);
    cmp("t7_cycles", cap_cycles, 1);
    clr_launch(6, 1, 3);
    launch(1, 0, 0, 2, 3, 0);
    cmp("t9_cycles", cap_cycles, 2);
    req_valid_i = 1'b0; cu_done_i = 1'b0; cu_exec_i = 1'b0; rsp_ready_i = 1'b0;
    e_ready = 1'b1; e_busy = 1'b0; e_conf = 1'b0; e_start = 1'b0; e_clr = 1'b0; e_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
